// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Turns the PLL lock flag into staged, synchronous, active-high resets for one
// clock domain. Release order is SDRAM controller, then CPU/cache, then
// peripherals. All three resets re-assert together on lock loss. Lock-loss
// events seen after the first release are counted, saturating at 255.
module pll_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP_CYCLES   = 16
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       pll_locked_i,
   output logic       rst_sdram_ctrl_o,
   output logic       rst_cpu_o,
   output logic       rst_periph_o,
   output logic       ready_o,
   output logic [7:0] lock_loss_count_o
);

   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                            LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
   // Keep at least one bit so the counter exists when both lengths are 1.
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_REL_SDRAM,
      ST_REL_CPU,
      ST_RUN
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [7:0]             loss_cnt_q, loss_cnt_d;
   logic                   rst_sdram_q, rst_cpu_q, rst_periph_q, ready_q;

   // Bring the asynchronous lock flag into the clock domain.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
      end
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   // State, stage counter and lock-loss counter registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= ST_WAIT_LOCK;
         cnt_q      <= '0;
         loss_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         loss_cnt_q <= loss_cnt_d;
      end
   end

   // Next-state logic; lock loss after release wins over any stage advance.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      loss_cnt_d = loss_cnt_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            cnt_d = '0;
            if (locked_s) begin
               state_d = ST_STABLE;
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = ST_REL_SDRAM;
               cnt_d   = '0;
            end
         end
         ST_REL_SDRAM, ST_REL_CPU, ST_RUN: begin
            if (state_q == ST_RUN) begin
               cnt_d = '0;
            end
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
               if (loss_cnt_q != 8'hFF) begin
                  loss_cnt_d = loss_cnt_q + 8'd1;
               end
            end else if (state_q != ST_RUN && cnt_q == GAP_LAST) begin
               state_d = (state_q == ST_REL_SDRAM) ? ST_REL_CPU : ST_RUN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // Reset outputs are decoded from the next state so they move on the same
   // edge as the state change while still coming straight from flops.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rst_sdram_q  <= 1'b1;
         rst_cpu_q    <= 1'b1;
         rst_periph_q <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         rst_sdram_q  <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE);
         rst_cpu_q    <= !((state_d == ST_REL_CPU) || (state_d == ST_RUN));
         rst_periph_q <= (state_d != ST_RUN);
         ready_q      <= (state_d == ST_RUN);
      end
   end

   assign rst_sdram_ctrl_o  = rst_sdram_q;
   assign rst_cpu_o         = rst_cpu_q;
   assign rst_periph_o      = rst_periph_q;
   assign ready_o           = ready_q;
   assign lock_loss_count_o = loss_cnt_q;

endmodule
